seq_pattern_tx: RTL and testbench

SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

---
 rtl/seq_pkg.sv | 21 ++
 rtl/seq1001_tracker.sv | 58 +++++
 rtl/seq_pattern_tx.sv | 121 ++++++++++++
 tb/tb_seq_pattern_tx.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and default widths for the serial
// pattern transmitter and its 1001 tracker.
package seq_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_CNT_W  = 8;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } fsm_t;

   typedef enum logic [1:0] {
      T0,
      T1,
      T2,
      T3
   } trk_t;

endpackage

// File: rtl/seq1001_tracker.sv
// Non-overlapping "1001" detector on the serial stream
// with a saturating match counter.
module seq1001_tracker
   import seq_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             bit_valid,
   input  logic             bit_in,
   output logic [CNT_W-1:0] match_cnt
);

   trk_t             trk_q, trk_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hit;

   // tracker walk and counter update for this cycle's bit
   always_comb begin
      trk_d = trk_q;
      hit   = 1'b0;
      cnt_d = cnt_q;
      if (bit_valid) begin
         unique case (trk_q)
            T0: trk_d = bit_in ? T1 : T0;
            T1: trk_d = bit_in ? T1 : T2;
            T2: trk_d = bit_in ? T1 : T3;
            T3: begin
               trk_d = T0;
               hit   = bit_in;
            end
         endcase
      end
      if (hit && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      if (clr) begin
         trk_d = T0;
         cnt_d = '0;
      end
   end

   // tracker and counter registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         trk_q <= T0;
         cnt_q <= '0;
      end else begin
         trk_q <= trk_d;
         cnt_q <= cnt_d;
      end
   end

   assign match_cnt = cnt_q;

endmodule

// File: rtl/seq_pattern_tx.sv
// Repeating MSB-first pattern serializer; counts
// "1001" occurrences in the emitted stream.
module seq_pattern_tx
   import seq_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [DATA_W-1:0] load_data,
   input  logic [3:0]        load_len,
   input  logic [3:0]        load_reps,
   output logic              dout,
   output logic              dout_valid,
   output logic              done,
   output logic [CNT_W-1:0]  match_cnt
);

   localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   fsm_t              state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [IW-1:0]     top_q, top_d;
   logic [3:0]        reps_q, reps_d;
   logic [IW-1:0]     top_w;
   logic              accept;
   logic              last_bit;

   assign accept   = (state_q == IDLE) && load_valid;
   assign last_bit = (idx_q == '0) && (reps_q == 4'd0);

   // top bit index from the requested length; 0 or
   // oversize lengths mean the full register
   always_comb begin
      if ((load_len == 4'd0) || (int'(load_len) > DATA_W)) begin
         top_w = IW'(DATA_W - 1);
      end else begin
         top_w = IW'(load_len - 4'd1);
      end
   end

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (accept) state_d = SHIFT;
         SHIFT: if (last_bit) state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // outputs decoded from state
   always_comb begin
      load_ready = (state_q == IDLE);
      dout_valid = (state_q == SHIFT);
      dout       = (state_q == SHIFT) ? data_q[idx_q] : 1'b0;
      done       = (state_q == DONE);
   end

   // bit index wraps to the top on each repetition
   always_comb begin
      data_d = data_q;
      idx_d  = idx_q;
      top_d  = top_q;
      reps_d = reps_q;
      if (accept) begin
         data_d = load_data;
         idx_d  = top_w;
         top_d  = top_w;
         reps_d = load_reps;
      end else if ((state_q == SHIFT) && !last_bit) begin
         if (idx_q == '0) begin
            idx_d  = top_q;
            reps_d = reps_q - 4'd1;
         end else begin
            idx_d = idx_q - IW'(1);
         end
      end
   end

   // job datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q <= '0;
         idx_q  <= '0;
         top_q  <= '0;
         reps_q <= '0;
      end else begin
         data_q <= data_d;
         idx_q  <= idx_d;
         top_q  <= top_d;
         reps_q <= reps_d;
      end
   end

   seq1001_tracker #(
      .CNT_W(CNT_W)
   ) u_trk (
      .clk      (clk),
      .reset    (reset),
      .clr      (accept),
      .bit_valid(dout_valid),
      .bit_in   (dout),
      .match_cnt(match_cnt)
   );

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed scoreboard bench for seq_pattern_tx.
// A second instance with a 2-bit counter checks saturation.
module tb_seq_pattern_tx;

   logic       clk = 1'b0;
   logic       reset;
   logic       load_valid;
   logic [7:0] load_data;
   logic [3:0] load_len;
   logic [3:0] load_reps;
   logic       load_ready, dout, dout_valid, done;
   logic [7:0] match_cnt;
   logic       s_ready, s_dout, s_valid, s_done;
   logic [1:0] s_cnt;

   int n_chk  = 0;
   int n_fail = 0;
   bit exp_q[$];

   always #5 clk = ~clk;

   seq_pattern_tx #(.DATA_W(8), .CNT_W(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .load_valid(load_valid),
      .load_ready(load_ready),
      .load_data (load_data),
      .load_len  (load_len),
      .load_reps (load_reps),
      .dout      (dout),
      .dout_valid(dout_valid),
      .done      (done),
      .match_cnt (match_cnt)
   );

   seq_pattern_tx #(.DATA_W(8), .CNT_W(2)) dut_sat (
      .clk       (clk),
      .reset     (reset),
      .load_valid(load_valid),
      .load_ready(s_ready),
      .load_data (load_data),
      .load_len  (load_len),
      .load_reps (load_reps),
      .dout      (s_dout),
      .dout_valid(s_valid),
      .done      (s_done),
      .match_cnt (s_cnt)
   );

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
      end
   endtask

   task automatic push_stream(input logic [7:0] d,
                              input int len,
                              input int reps);
      int l;
      l = (len == 0 || len > 8) ? 8 : len;
      for (int r = 0; r <= reps; r++)
         for (int i = l - 1; i >= 0; i--)
            exp_q.push_back(d[i]);
   endtask

   // drive one job; returns in the first SHIFT cycle
   task automatic start_job(input logic [7:0] d,
                            input int len,
                            input int reps);
      @(negedge clk);
      check("ready_before_load", load_ready, 1);
      load_valid = 1'b1;
      load_data  = d;
      load_len   = 4'(len);
      load_reps  = 4'(reps);
      push_stream(d, len, reps);
      @(negedge clk);
      load_valid = 1'b0;
   endtask

   // consume the queued stream, then check DONE and IDLE
   task automatic drain(input string tag,
                        input int exp_cnt);
      while (exp_q.size() > 0) begin
         check({tag, "_valid"}, dout_valid, 1);
         check({tag, "_bit"}, dout, exp_q.pop_front());
         check({tag, "_ready_busy"}, load_ready, 0);
         @(negedge clk);
      end
      check({tag, "_done"}, done, 1);
      check({tag, "_done_valid"}, dout_valid, 0);
      check({tag, "_cnt"}, match_cnt, exp_cnt);
      @(negedge clk);
      check({tag, "_done_clr"}, done, 0);
      check({tag, "_idle_ready"}, load_ready, 1);
      check({tag, "_cnt_hold"}, match_cnt, exp_cnt);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      reset      = 1'b1;
      load_valid = 1'b0;
      load_data  = '0;
      load_len   = '0;
      load_reps  = '0;
      #1;
      check("rst_dout", dout, 0);
      check("rst_valid", dout_valid, 0);
      check("rst_done", done, 0);
      check("rst_cnt", match_cnt, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_ready", load_ready, 1);

      start_job(8'h99, 8, 0);
      drain("j99", 2);

      start_job(8'h09, 4, 2);
      drain("j09x3", 3);

      start_job(8'h49, 7, 0);
      drain("j49", 1);

      start_job(8'h90, 0, 0);
      drain("len0", 1);

      start_job(8'h05, 12, 0);
      drain("clamp", 0);

      start_job(8'h99, 8, 3);
      check("sat_first", s_valid, 1);
      drain("sat8", 8);
      check("sat_cnt", s_cnt, 3);

      // load_valid held high across a whole job
      @(negedge clk);
      load_valid = 1'b1;
      load_data  = 8'h09;
      load_len   = 4'd4;
      load_reps  = 4'd0;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         check("hold_valid", dout_valid, 1);
         check("hold_ready", load_ready, 0);
         @(negedge clk);
      end
      check("hold_done", done, 1);
      check("hold_cnt", match_cnt, 1);
      @(negedge clk);
      check("hold_gap_valid", dout_valid, 0);
      check("hold_reaccept", load_ready, 1);
      push_stream(8'h09, 4, 0);
      @(negedge clk);
      load_valid = 1'b0;
      check("hold_done_once", done, 0);
      drain("hold2", 1);

      // reset while data bit 3 is on the line
      start_job(8'h99, 8, 0);
      for (int i = 0; i < 4; i++) begin
         void'(exp_q.pop_front());
         @(negedge clk);
      end
      check("mid_cnt", match_cnt, 1);
      check("mid_bit3", dout, exp_q.pop_front());
      exp_q.delete();
      reset = 1'b1;
      #1;
      check("abort_dout", dout, 0);
      check("abort_valid", dout_valid, 0);
      check("abort_done", done, 0);
      check("abort_cnt", match_cnt, 0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("abort_no_done", done, 0);
         check("abort_no_valid", dout_valid, 0);
         check("abort_ready", load_ready, 1);
         @(negedge clk);
      end
      start_job(8'h99, 8, 0);
      drain("after_rst", 2);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
